// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   imem_req   : request valid, held until acknowledged
//   imem_addr  : request address, stable while imem_req=1
//   imem_ack   : response valid (only meaningful while imem_req=1)
//   imem_rdata : instruction word, valid with imem_ack
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  // Fetch stage side: issues requests, consumes responses
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side: accepts requests, returns responses
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, keeps at most one imem request outstanding, and presents the
// fetched instruction to decode. Execute-stage redirects flush the IF/ID slot
// and discard any fetch already in flight.
//   clk, rst          : clock, asynchronous active-high reset
//   bus (master)      : imem_req/imem_addr out, imem_ack/imem_rdata in
//   stall             : decode cannot consume the IF/ID slot this cycle
//   ex_jump           : unconditional redirect
//   ex_branchZero/Neg : conditional branch in execute
//   ex_zero/ex_neg    : ALU flags qualifying the branches
//   ex_target         : redirect target PC
//   id_valid/instr/pc : IF/ID slot contents
//   id_opcode         : slot opcode, NOP (0) when slot is empty
module fetch_stage #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  fetch_stage_if.master       bus,
  input  logic                stall,
  input  logic                ex_jump,
  input  logic                ex_branchZero,
  input  logic                ex_branchNeg,
  input  logic                ex_zero,
  input  logic                ex_neg,
  input  logic [ADDR_W-1:0]   ex_target,
  output logic                id_valid,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [ADDR_W-1:0]   id_pc,
  output logic [3:0]          id_opcode
);

  localparam int unsigned OPC_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                imem_req_q, imem_req_d;
  logic                id_valid_q, id_valid_d;
  logic [INSTR_W-1:0]  id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]   id_pc_q, id_pc_d;

  logic redirect_c;
  logic issue_c;
  logic ack_c;
  logic fill_c;

  // Redirect decode from execute
  assign redirect_c = ex_jump
                    | (ex_branchZero & ex_zero)
                    | (ex_branchNeg  & ex_neg);

  // A new fetch may start only if the slot is free or being consumed now
  assign issue_c = !redirect_c && (!id_valid_q || !stall);

  // Ack is only honoured while a request is outstanding
  assign ack_c = bus.imem_ack & imem_req_q;

  // Only a non-redirected ack in BUSY delivers an instruction
  assign fill_c = (state_q == BUSY) && ack_c && !redirect_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      req_addr_q <= '0;
      imem_req_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      imem_req_q <= imem_req_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue_c) state_d = BUSY;
      end
      BUSY: begin
        // A redirect with ack drops the data and returns to IDLE directly
        if (ack_c)           state_d = IDLE;
        else if (redirect_c) state_d = FLUSH;
      end
      FLUSH: begin
        if (ack_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    imem_req_d = (state_d != IDLE);

    // Decode consumes the slot
    if (id_valid_q && !stall) id_valid_d = 1'b0;

    if ((state_q == IDLE) && issue_c) req_addr_d = pc_q;

    if (fill_c) begin
      id_instr_d = bus.imem_rdata;
      id_pc_d    = req_addr_q;
      id_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(1);
    end

    // Redirect wins over stall and ack; req_addr is left alone in FLUSH
    if (redirect_c) begin
      pc_d       = ex_target;
      id_valid_d = 1'b0;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = req_addr_q;

  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_opcode = id_valid_q ? id_instr_q[INSTR_W-1 -: OPC_W] : OPC_W'(0);

`ifndef SYNTHESIS
  // An ack in BUSY must never land on an occupied slot
  always @(posedge clk) begin
    if (!rst && (state_q == BUSY) && ack_c) begin
      assert (!id_valid_q)
        else $error("fetch_stage: ack in BUSY while IF/ID slot occupied");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a latency-programmable memory
// model and a scoreboard of expected request addresses and slot fills.
module tb_fetch_stage;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic ex_jump = 1'b0, ex_branchZero = 1'b0, ex_branchNeg = 1'b0;
  logic ex_zero = 1'b0, ex_neg = 1'b0;
  logic [ADDR_W-1:0]  ex_target = '0;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic [3:0]         id_opcode;

  int lat = 0;
  logic stray_ack = 1'b0;
  int wait_cnt;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .stall         (stall),
    .ex_jump       (ex_jump),
    .ex_branchZero (ex_branchZero),
    .ex_branchNeg  (ex_branchNeg),
    .ex_zero       (ex_zero),
    .ex_neg        (ex_neg),
    .ex_target     (ex_target),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_opcode     (id_opcode)
  );

  always #5 clk = ~clk;

  // Memory model: ack after 'lat' wait cycles, data = 0x4000_0000 + addr
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign bus.imem_ack   = (bus.imem_req && (wait_cnt >= lat)) || stray_ack;
  assign bus.imem_rdata = 32'h4000_0000 + 32'(bus.imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  logic [ADDR_W-1:0] addr_q[$];
  exp_t              exp_q[$];
  logic prev_req = 1'b0, prev_valid = 1'b0, fill_pending = 1'b0, discard = 1'b0;

  // Scoreboard monitor: samples late in the cycle, after inputs settle
  always begin
    logic redir;
    exp_t e;
    @(negedge clk);
    #3;
    redir = ex_jump | (ex_branchZero & ex_zero) | (ex_branchNeg & ex_neg);
    if (rst) begin
      exp_q.delete();
      fill_pending = 1'b0;
      discard      = 1'b0;
      prev_req     = 1'b0;
      prev_valid   = 1'b0;
    end else begin
      if (fill_pending && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fill_valid", 64'(id_valid), 64'(1));
        chk("fill_pc", 64'(id_pc), 64'(e.pc));
        chk("fill_instr", 64'(id_instr), 64'(e.instr));
        chk("fill_opcode", 64'(id_opcode), 64'(e.instr[31:28]));
      end else begin
        chk("no_fill", 64'(id_valid & ~prev_valid), 64'(0));
      end
      if (!id_valid) chk("opcode_nop", 64'(id_opcode), 64'(0));
      if (bus.imem_req && !prev_req && addr_q.size() > 0)
        chk("req_addr", 64'(bus.imem_addr), 64'(addr_q.pop_front()));
      fill_pending = 1'b0;
      if (bus.imem_req && bus.imem_ack) begin
        chk("no_overwrite", 64'(id_valid), 64'(0));
        if (!redir && !discard) begin
          exp_q.push_back('{pc: bus.imem_addr, instr: bus.imem_rdata});
          fill_pending = 1'b1;
        end
        discard = 1'b0;
      end else if (bus.imem_req && redir) begin
        discard = 1'b1;
      end
      prev_req   = bus.imem_req;
      prev_valid = id_valid;
    end
  end

  task automatic wait_fill(input logic [ADDR_W-1:0] a, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(id_valid && id_pc == a) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk(tag, 64'(id_pc), 64'(a));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},    64'(bus.imem_req),  64'(0));
    chk({tag, "_addr"},   64'(bus.imem_addr), 64'(0));
    chk({tag, "_valid"},  64'(id_valid),      64'(0));
    chk({tag, "_instr"},  64'(id_instr),      64'(0));
    chk({tag, "_pc"},     64'(id_pc),         64'(0));
    chk({tag, "_opcode"}, 64'(id_opcode),     64'(0));
  endtask

  initial begin
    int n;
    // Reset state
    @(negedge clk);
    chk_reset_outputs("rst0");
    #1 rst = 1'b0;
    addr_q.push_back(8'h00);
    addr_q.push_back(8'h01);
    addr_q.push_back(8'h02);

    // Sequential zero-wait fetch 0,1,2
    wait_fill(8'h02, "t1_tmo");

    // Stall holds the slot and blocks new requests
    #1 stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t2_valid", 64'(id_valid), 64'(1));
      chk("t2_pc", 64'(id_pc), 64'(8'h02));
      chk("t2_instr", 64'(id_instr), 64'(32'h4000_0002));
      chk("t2_noreq", 64'(bus.imem_req), 64'(0));
    end
    #1 stall = 1'b0;
    addr_q.push_back(8'h03);
    wait_fill(8'h03, "t2_tmo");

    // Jump during a slow fetch to addr 5: data discarded, refetch at 0x40
    #1 lat = 3;
    addr_q.push_back(8'h04);
    addr_q.push_back(8'h05);
    addr_q.push_back(8'h40);
    n = 0;
    @(negedge clk);
    while (!(bus.imem_req && bus.imem_addr == 8'h05) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("t3_tmo_req5", 64'(bus.imem_addr), 64'(8'h05));
    @(negedge clk);
    #1 ex_jump = 1'b1; ex_target = 8'h40;
    @(negedge clk);
    chk("t3_flush_req", 64'(bus.imem_req), 64'(1));
    chk("t3_flush_addr", 64'(bus.imem_addr), 64'(8'h05));
    chk("t3_flush_valid", 64'(id_valid), 64'(0));
    #1 ex_jump = 1'b0;
    wait_fill(8'h40, "t3_tmo");

    // Untaken branch-zero keeps sequential fetch
    #1 lat = 0; ex_branchZero = 1'b1; ex_zero = 1'b0;
    addr_q.push_back(8'h41);
    addr_q.push_back(8'h42);
    addr_q.push_back(8'h43);
    wait_fill(8'h43, "t4_tmo_seq");

    // Taken branch-neg redirects to 0x10
    #1 ex_branchZero = 1'b0; ex_branchNeg = 1'b1; ex_neg = 1'b1; ex_target = 8'h10;
    addr_q.push_back(8'h10);
    @(negedge clk);
    chk("t4_flush_valid", 64'(id_valid), 64'(0));
    #1 ex_branchNeg = 1'b0; ex_neg = 1'b0;
    wait_fill(8'h10, "t4_tmo");

    // PC wrap: fetch 0xFF then 0x00
    #1 ex_jump = 1'b1; ex_target = 8'hFF;
    addr_q.push_back(8'hFF);
    addr_q.push_back(8'h00);
    @(negedge clk);
    #1 ex_jump = 1'b0;
    wait_fill(8'hFF, "t5_tmo_ff");
    wait_fill(8'h00, "t5_tmo_00");

    // Reset mid-transaction, stray ack afterwards is ignored
    #1 lat = 20;
    n = 0;
    @(negedge clk);
    while (!bus.imem_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("t6_tmo_req", 64'(bus.imem_req), 64'(1));
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("t6_rst");
    #1 rst = 1'b0; stray_ack = 1'b1; lat = 0;
    addr_q.push_back(8'h00);
    @(negedge clk);
    #1 stray_ack = 1'b0;
    chk("t6_req", 64'(bus.imem_req), 64'(1));
    chk("t6_addr", 64'(bus.imem_addr), 64'(0));
    chk("t6_valid", 64'(id_valid), 64'(0));
    wait_fill(8'h00, "t6_tmo");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage with the IF/ID pipeline register. It owns the program counter and issues one-outstanding requests to instruction memory. It presents the fetched instruction and its opcode to the decode/control stage. Redirects (jump, taken branch, jump-memory) are taken from the execute stage, which flushes the IF/ID slot and discards any in-flight fetch.

## Interface
- ADDR_W, 8, width of the PC and instruction-memory address
- INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDR_W  address of outstanding request; stable while imem_req=1
- imem_ack  in  1  memory response valid; sampled only while imem_req=1
- imem_rdata  in  INSTR_W  instruction, valid with imem_ack
- stall  in  1  decode cannot consume IF/ID this cycle
- ex_jump  in  1  unconditional redirect (jump and jump-memory both assert it)
- ex_branchZero  in  1  branch-if-zero in execute
- ex_branchNeg  in  1  branch-if-negative in execute
- ex_zero  in  1  ALU zero flag
- ex_neg  in  1  ALU negative flag
- ex_target  in  ADDR_W  redirect target (register or data-memory sourced, already muxed)
- id_valid  out  1  IF/ID slot holds a valid instruction
- id_instr  out  INSTR_W  IF/ID instruction
- id_pc  out  ADDR_W  address of id_instr (consumed by save-PC)
- id_opcode  out  4  id_instr opcode when id_valid, else 4'b0000 (NOP), combinational from registers

## Operation
- Redirect is `redirect = ex_jump | (ex_branchZero & ex_zero) | (ex_branchNeg & ex_neg)`.
- Registers: pc, req_addr, state ∈ {IDLE, BUSY, FLUSH}, id_valid, id_instr, id_pc.
- Reset values: pc=0, state=IDLE, imem_req=0, imem_addr=0, id_valid=0, id_instr=0, id_pc=0, id_opcode=0.
- imem_req=1 exactly in BUSY and FLUSH. imem_addr=req_addr.
- Slot consume: when id_valid=1 and stall=0, the slot empties at the next edge unless it is refilled.

**IDLE**
- Issue condition: !redirect && (!id_valid || !stall).
- When the issue condition holds: req_addr<=pc, go to BUSY.
- Otherwise stay in IDLE.

**BUSY, ack=1, no redirect**
- id_instr<=imem_rdata, id_pc<=req_addr, id_valid<=1.
- pc<=pc+1.
- Go to IDLE.

**BUSY, ack=0, no redirect**
- Hold.

**FLUSH**
- On ack: discard imem_rdata and go to IDLE.
- Without ack: hold.

**Redirect (highest priority, overrides stall and ack)**
- pc<=ex_target and id_valid<=0.
- BUSY without ack: go to FLUSH.
- BUSY with ack: data discarded, go to IDLE.
- FLUSH with ack: go to IDLE.
- FLUSH without ack: stay in FLUSH.
- IDLE: stay in IDLE.
- A redirect during FLUSH updates pc again; req_addr is unchanged.

**Other rules**
- PC arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-1 increments to 0.
- The slot is always empty when an ack arrives in BUSY, so no overwrite is possible. Verification asserts this.

## Timing
- Single clock domain. There are no combinational paths from imem_ack/imem_rdata to imem_req/imem_addr.
- id_opcode is combinational from registers only.
- Minimum fetch latency with zero-wait memory: issue edge to id_valid is 2 edges.
  - Cycle n: IDLE.
  - Cycle n+1: imem_req=1 and ack.
  - Cycle n+2: id_valid=1.
- Peak throughput is one instruction per 2 cycles.
- Redirect to first target request:
  - Redirect seen in cycle n.
  - In IDLE at n+1, with imem_addr=target at n+2.
  - If the redirect lands in FLUSH, the target request follows one cycle after the stale ack.
- Asynchronous reset mid-transaction: all state returns to reset values immediately. Any later ack while imem_req=0 is ignored.

## Test plan
1. Reset, then zero-wait memory returning 32'h4000_0000+addr, stall=0 -> imem_addr sequence 0,1,2,3 every 2 cycles. id_pc=0,1,2,3; id_opcode=4'b0100 whenever id_valid=1.
2. stall=1 held for 5 cycles while id_valid=1, id_pc=2 -> id_instr/id_pc stable, no new imem_req. Releasing stall gives the next request at addr 3.
3. Memory with 3-cycle ack latency; ex_jump=1, ex_target=8'h40 one cycle after the request to addr 5 -> state FLUSH and id_valid=0. The addr-5 data is discarded, and the next request has imem_addr=8'h40.
4. ex_branchZero=1 with ex_zero=0, then ex_branchNeg=1 with ex_neg=1 and target 8'h10 -> first: no redirect, fetch continues sequentially. Second: redirect, id_valid cleared, next fetch at 8'h10.
5. pc=8'hFF, ack -> id_pc=8'hFF, next imem_addr=8'h00.
6. Assert rst while in BUSY, then pulse imem_ack after release -> all outputs 0 during reset, the stray ack is ignored, and the first post-reset fetch is addr 0.
